// File: rtl/hazard_pkg.sv
// Shared types and bounds for the pipeline hazard controller.
package hazard_pkg;

    localparam int LOAD_LAT_DEF = 1;
    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 3;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_x;
        logic stall_m;
        logic flush_d;
        logic flush_x;
        logic bubble_w;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE = '0;
    localparam hz_ctrl_t CTRL_LOAD = 7'b1100010;
    localparam hz_ctrl_t CTRL_MEM  = 7'b1111001;
    localparam hz_ctrl_t CTRL_BR   = 7'b0000110;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller signal bundle; the pipeline is master.
interface hazard_ctrl_unit_if;
    logic [4:0] rs1_D, rs2_D, rd_X;
    logic       use_rs1_D, use_rs2_D;
    logic       memread_X, branch_taken_X;
    logic       mem_req_M, mem_ready_M;
    logic       stall_F, stall_D, stall_X, stall_M;
    logic       flush_D, flush_X, bubble_W;

    modport master (
        output rs1_D, rs2_D, rd_X, use_rs1_D, use_rs2_D,
               memread_X, branch_taken_X, mem_req_M, mem_ready_M,
        input  stall_F, stall_D, stall_X, stall_M, flush_D, flush_X, bubble_W
    );

    modport slave (
        input  rs1_D, rs2_D, rd_X, use_rs1_D, use_rs2_D,
               memread_X, branch_taken_X, mem_req_M, mem_ready_M,
        output stall_F, stall_D, stall_X, stall_M, flush_D, flush_X, bubble_W
    );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Stall/flush event counters, present only in HAZARD_PERF_EN builds.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        flush_D,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_F) stall_cycles <= stall_cycles + 32'd1;
            if (flush_D) flush_count  <= flush_count + 32'd1;
        end
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch / memory-wait hazard controller with zero-latency stall decision.
// Optional HAZARD_PERF_EN adds stall_cycles and flush_count counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_unit_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);
    if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_lat
        $error("hazard_ctrl_unit: LOAD_LAT out of range");
    end

    hz_state_t  state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       ret, ret_nxt;
    hz_ctrl_t   ctrl;
    logic       mem_busy, load_use;

    assign mem_busy = hz.mem_req_M & ~hz.mem_ready_M;
    assign load_use = (state == RUN) & hz.memread_X & (hz.rd_X != 5'd0) &
                      ((hz.use_rs1_D & (hz.rd_X == hz.rs1_D)) |
                       (hz.use_rs2_D & (hz.rd_X == hz.rs2_D)));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ret_nxt   = ret;
        ctrl      = CTRL_NONE;
        if (mem_busy) begin
            // freeze the whole pipe; remember whether a load bubble was in flight
            ctrl = CTRL_MEM;
            if (state != MEM_WAIT) begin
                state_nxt = MEM_WAIT;
                ret_nxt   = (state == LOAD_STALL);
            end
        end else if (hz.branch_taken_X) begin
            ctrl      = CTRL_BR;
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
            ret_nxt   = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        ctrl = CTRL_LOAD;
                        if (LOAD_LAT > 1) begin
                            state_nxt = LOAD_STALL;
                            cnt_nxt   = 2'(LOAD_LAT - 1);
                        end
                    end
                end
                LOAD_STALL: begin
                    ctrl    = CTRL_LOAD;
                    cnt_nxt = cnt - 2'd1;
                    if (cnt <= 2'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 2'd0;
                    end
                end
                MEM_WAIT: begin
                    ret_nxt   = 1'b0;
                    state_nxt = (ret && cnt != 2'd0) ? LOAD_STALL : RUN;
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 2'd0;
                    ret_nxt   = 1'b0;
                end
            endcase
        end
        if (rst) ctrl = CTRL_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 2'd0;
            ret   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ret   <= ret_nxt;
        end
    end

    assign hz.stall_F  = ctrl.stall_f;
    assign hz.stall_D  = ctrl.stall_d;
    assign hz.stall_X  = ctrl.stall_x;
    assign hz.stall_M  = ctrl.stall_m;
    assign hz.flush_D  = ctrl.flush_d;
    assign hz.flush_X  = ctrl.flush_x;
    assign hz.bubble_W = ctrl.bubble_w;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_F      (ctrl.stall_f),
        .flush_D      (ctrl.flush_d),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: LOAD_LAT=1 and LOAD_LAT=3 controllers driven with the same stimulus.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit_if if1 ();
    hazard_ctrl_unit_if if3 ();

`ifdef HAZARD_PERF_EN
    logic [31:0] sc1, fc1, sc3, fc3;
`endif

    hazard_ctrl_unit #(.LOAD_LAT(1)) u1 (
        .clk (clk), .rst (rst), .hz (if1)
`ifdef HAZARD_PERF_EN
        , .stall_cycles (sc1), .flush_count (fc1)
`endif
    );

    hazard_ctrl_unit #(.LOAD_LAT(3)) u3 (
        .clk (clk), .rst (rst), .hz (if3)
`ifdef HAZARD_PERF_EN
        , .stall_cycles (sc3), .flush_count (fc3)
`endif
    );

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LDB  = 7'b1100010;
    localparam logic [6:0] MEMS = 7'b1111001;
    localparam logic [6:0] BRF  = 7'b0000110;

    function automatic logic [6:0] outs1();
        return {if1.stall_F, if1.stall_D, if1.stall_X, if1.stall_M,
                if1.flush_D, if1.flush_X, if1.bubble_W};
    endfunction

    function automatic logic [6:0] outs3();
        return {if3.stall_F, if3.stall_D, if3.stall_X, if3.stall_M,
                if3.flush_D, if3.flush_X, if3.bubble_W};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // output vector check plus the stall/flush exclusivity rule
    task automatic chk_o(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        chk(tag, 32'(obs), 32'(exp));
        chk({tag, "_excl"}, 32'((obs[4] & obs[1]) | (obs[5] & obs[2])), 32'd0);
    endtask

    task automatic drv(input logic [4:0] rd, input logic mr, input logic [4:0] rs1,
                       input logic u1s, input logic [4:0] rs2, input logic u2s,
                       input logic br, input logic mreq, input logic mrdy);
        if1.rd_X = rd;  if1.memread_X = mr;  if1.rs1_D = rs1; if1.use_rs1_D = u1s;
        if1.rs2_D = rs2; if1.use_rs2_D = u2s; if1.branch_taken_X = br;
        if1.mem_req_M = mreq; if1.mem_ready_M = mrdy;
        if3.rd_X = rd;  if3.memread_X = mr;  if3.rs1_D = rs1; if3.use_rs1_D = u1s;
        if3.rs2_D = rs2; if3.use_rs2_D = u2s; if3.branch_taken_X = br;
        if3.mem_req_M = mreq; if3.mem_ready_M = mrdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset forces outputs low even with a hazard present
        drv(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk_o("rst_out1", outs1(), NONE);
        chk_o("rst_out3", outs3(), NONE);
        chk("rst_state3", 32'(u3.state), 32'(RUN));
        chk("rst_cnt3", 32'(u3.cnt), 32'd0);

        // load-use, both latencies
        step(); rst = 1'b0; #1;
        chk_o("lat1_c1", outs1(), LDB);
        chk_o("lat3_c1", outs3(), LDB);
        step();
        drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_o("lat1_after", outs1(), NONE);
        chk("lat1_state", 32'(u1.state), 32'(RUN));
        chk_o("lat3_c2", outs3(), LDB);
        chk("lat3_cnt2", 32'(u3.cnt), 32'd2);
        step();
        chk_o("lat3_c3", outs3(), LDB);
        chk("lat3_cnt1", 32'(u3.cnt), 32'd1);
        step();
        chk_o("lat3_done", outs3(), NONE);
        chk("lat3_state", 32'(u3.state), 32'(RUN));

        // x0 destination and unused source never stall
        step();
        drv(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_o("x0_rs1", outs1(), NONE);
        drv(5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_o("rs2_unused", outs1(), NONE);
        drv(5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk_o("rs2_used", outs1(), LDB);

        // branch beats load-use, one cycle only
        drv(5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk_o("br_lu1", outs1(), BRF);
        chk_o("br_lu3", outs3(), BRF);
        step();
        drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_o("br_after1", outs1(), NONE);
        chk_o("br_after3", outs3(), NONE);
        chk("br_state3", 32'(u3.state), 32'(RUN));
        drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk_o("mem_ready", outs3(), NONE);

        // branch during LOAD_STALL cancels remaining bubbles
        step();
        drv(5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_o("lsbr_c1", outs3(), LDB);
        step();
        drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk_o("lsbr_c2", outs3(), BRF);
        chk("lsbr_st", 32'(u3.state), 32'(LOAD_STALL));
        step();
        drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_o("lsbr_c3", outs3(), NONE);
        chk("lsbr_run", 32'(u3.state), 32'(RUN));
        chk("lsbr_cnt", 32'(u3.cnt), 32'd0);

        // memory wait in the second bubble cycle
        step();
        drv(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_o("mw_c1", outs3(), LDB);
        step();
        drv(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk_o("mw_c2", outs3(), MEMS);
        chk_o("mw_c2_u1", outs1(), MEMS);
        chk("mw_c2_st", 32'(u3.state), 32'(LOAD_STALL));
        for (int i = 3; i <= 5; i++) begin
            step();
            chk_o($sformatf("mw_c%0d", i), outs3(), MEMS);
            chk($sformatf("mw_c%0d_st", i), 32'(u3.state), 32'(MEM_WAIT));
        end
        chk("mw_ret", 32'(u3.ret), 32'd1);
        chk("mw_cnt", 32'(u3.cnt), 32'd2);
        step();
        drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_o("mw_c6", outs3(), NONE);
        step();
        chk_o("mw_c7", outs3(), LDB);
        chk("mw_c7_st", 32'(u3.state), 32'(LOAD_STALL));
        chk("mw_c7_cnt", 32'(u3.cnt), 32'd2);
        step();
        chk_o("mw_c8", outs3(), LDB);
        chk("mw_c8_cnt", 32'(u3.cnt), 32'd1);
        step();
        chk_o("mw_c9", outs3(), NONE);
        chk("mw_c9_st", 32'(u3.state), 32'(RUN));

        // reset in the middle of MEM_WAIT
        step();
        drv(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drv(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk_o("rmw_busy", outs3(), MEMS);
        step();
        chk("rmw_st", 32'(u3.state), 32'(MEM_WAIT));
        rst = 1'b1;
        #1;
        chk_o("rmw_out3", outs3(), NONE);
        chk_o("rmw_out1", outs1(), NONE);
        chk("rmw_st3", 32'(u3.state), 32'(RUN));
        chk("rmw_cnt3", 32'(u3.cnt), 32'd0);
        chk("rmw_ret3", 32'(u3.ret), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("rmw_sc3", sc3, 32'd0);
        chk("rmw_fc3", fc3, 32'd0);
        chk("rmw_sc1", sc1, 32'd0);
        chk("rmw_fc1", fc1, 32'd0);
`endif
        step();
        rst = 1'b0;
        drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_o("rel_out3", outs3(), NONE);
        chk("rel_st3", 32'(u3.state), 32'(RUN));
        step();
        chk_o("rel2_out3", outs3(), NONE);
        chk_o("rel2_out1", outs1(), NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
